// File: rtl/proc_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg
// Shared constants for the 16-bit single-cycle processor datapath. Reused by
// the register file, ALU, control unit and testbenches.
//   DATA_W     : datapath / register width
//   ADDR_W     : register address width
//   NUM_REGS   : number of architectural registers (2**ADDR_W)
//   REG_ZERO   : address of the hardwired-zero register
//   FLAG_*     : bit positions of the ALU flags inside the status register
// ---------------------------------------------------------------------------
package proc_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = 3'd0;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_COUT = 1;
    localparam int FLAG_OVF  = 2;
    localparam int FLAG_W    = 3;

endpackage : proc_pkg

// File: rtl/status_flags.sv
// ---------------------------------------------------------------------------
// status_flags
// Enabled 3-bit status register holding the ALU flags, with asynchronous
// active-low clear.
//   clk    : system clock, captures on rising edge
//   rst_n  : asynchronous active-low clear
//   en     : load enable; when low the register holds
//   d      : next flag value, packed as {ovf, cout, zero}
//   q      : registered flags
// ---------------------------------------------------------------------------
module status_flags
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [FLAG_W-1:0] d,
    output logic [FLAG_W-1:0] q
);

    logic [FLAG_W-1:0] r_flags;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (en) begin
            r_flags <= d;
        end
    end

    assign q = r_flags;

endmodule : status_flags

// File: rtl/reg_file8x16.sv
// ---------------------------------------------------------------------------
// reg_file8x16
// Architectural register file feeding the ALU operands: eight registers
// (R0 hardwired to zero), two combinational read ports, one clocked write
// port, a debug read port and the ALU status-flag register.
//   clk, rst_n          : clock, asynchronous active-low reset
//   rs_addr / rs_data   : read port A (ALU operand A)
//   rt_addr / rt_data   : read port B (ALU operand B)
//   reg_write, rd_addr,
//   wr_data             : write port, committed on the rising edge
//   flag_en, alu_zero,
//   alu_ovf, alu_cout   : flag capture enable and ALU flag inputs
//   flags               : registered flags {ovf, cout, zero}
//   dbg_addr / dbg_data : debug read port
// ---------------------------------------------------------------------------
module reg_file8x16 #(
    parameter int DATA_W   = proc_pkg::DATA_W,
    parameter int ADDR_W   = proc_pkg::ADDR_W,
    parameter int NUM_REGS = proc_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flag_en,
    input  logic              alu_zero,
    input  logic              alu_ovf,
    input  logic              alu_cout,
    output logic [2:0]        flags,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    // Storage exists only for R1..R(NUM_REGS-1); R0 is a constant zero.
    logic [DATA_W-1:0] r_regs [1:NUM_REGS-1];
    logic [2:0]        w_flag_d;

    // NOTE: the array is reset element by element because the reset must
    // clear every register asynchronously; this keeps it in flops, not RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (reg_write) begin
            // rd_addr == 0 matches no index, so R0 writes fall away.
            for (int i = 1; i < NUM_REGS; i++) begin
                if (rd_addr == ADDR_W'(i)) begin
                    r_regs[i] <= wr_data;
                end
            end
        end
    end

    // Reads come from stored state only. There is deliberately no bypass of
    // wr_data: rs_data -> ALU -> wr_data would otherwise form a loop.
    // NOTE: each output is given a default first so no path leaves it
    // unassigned and no latch is inferred; the default doubles as the R0 value.
    always_comb begin
        rs_data  = '0;
        rt_data  = '0;
        dbg_data = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rs_addr  == ADDR_W'(i)) rs_data  = r_regs[i];
            if (rt_addr  == ADDR_W'(i)) rt_data  = r_regs[i];
            if (dbg_addr == ADDR_W'(i)) dbg_data = r_regs[i];
        end
    end

    always_comb begin
        w_flag_d                      = '0;
        w_flag_d[proc_pkg::FLAG_ZERO] = alu_zero;
        w_flag_d[proc_pkg::FLAG_COUT] = alu_cout;
        w_flag_d[proc_pkg::FLAG_OVF]  = alu_ovf;
    end

    status_flags u_status_flags (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (flag_en),
        .d     (w_flag_d),
        .q     (flags)
    );

endmodule : reg_file8x16

// File: tb/tb_reg_file8x16.sv
// ---------------------------------------------------------------------------
// tb_reg_file8x16
// Directed testbench for reg_file8x16. Expected values are pushed to a
// scoreboard queue as stimulus is applied and popped when the outputs are
// sampled (mid-cycle, away from the rising edge).
// ---------------------------------------------------------------------------
module tb_reg_file8x16;

    typedef enum {P_RS, P_RT, P_DBG, P_FLAGS} port_e;
    typedef struct {
        string       tag;
        port_e       port;
        logic [15:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  rs_addr, rt_addr, rd_addr, dbg_addr;
    logic [15:0] rs_data, rt_data, dbg_data, wr_data;
    logic        reg_write, flag_en, alu_zero, alu_ovf, alu_cout;
    logic [2:0]  flags;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] model [8];

    reg_file8x16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .reg_write (reg_write),
        .rd_addr   (rd_addr),
        .wr_data   (wr_data),
        .flag_en   (flag_en),
        .alu_zero  (alu_zero),
        .alu_ovf   (alu_ovf),
        .alu_cout  (alu_cout),
        .flags     (flags),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input port_e p, input logic [15:0] v);
        exp_t e;
        e.tag  = tag;
        e.port = p;
        e.exp  = v;
        sb.push_back(e);
    endtask

    // Pop every pending expectation and compare it with the live output.
    task automatic drain();
        exp_t        e;
        logic [15:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.port)
                P_RS:    obs = rs_data;
                P_RT:    obs = rt_data;
                P_DBG:   obs = dbg_data;
                default: obs = {13'b0, flags};
            endcase
            check(e.tag, obs, e.exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic write(input logic [2:0] a, input logic [15:0] d);
        reg_write = 1'b1;
        rd_addr   = a;
        wr_data   = d;
        if (a != 3'd0) model[a] = d;
        step();
        reg_write = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        rst_n = 1'b0;
        rs_addr = 3'd1; rt_addr = 3'd5; dbg_addr = 3'd7; rd_addr = 3'd0;
        wr_data = '0; reg_write = 1'b0; flag_en = 1'b0;
        alu_zero = 1'b0; alu_ovf = 1'b0; alu_cout = 1'b0;

        // Power-on reset state.
        #12;
        push("reset_rs", P_RS, 16'h0000);
        push("reset_rt", P_RT, 16'h0000);
        push("reset_dbg", P_DBG, 16'h0000);
        push("reset_flags", P_FLAGS, 16'h0000);
        drain();
        rst_n = 1'b1;

        // Test 1: async reset clears data and flags before the next edge.
        flag_en = 1'b1; alu_zero = 1'b1; alu_ovf = 1'b1; alu_cout = 1'b1;
        write(3'd1, 16'hBEEF);
        flag_en = 1'b0;
        push("t1_written", P_RS, 16'hBEEF);
        push("t1_flags_set", P_FLAGS, 16'h0007);
        drain();
        #2;
        reg_write = 1'b1; rd_addr = 3'd1; wr_data = 16'h1111;
        rst_n = 1'b0;
        #1;
        model[1] = 16'h0000;
        push("t1_async_rs", P_RS, 16'h0000);
        push("t1_async_flags", P_FLAGS, 16'h0000);
        drain();
        step();
        push("t1_reset_beats_write", P_RS, 16'h0000);
        drain();
        reg_write = 1'b0;
        rst_n = 1'b1;
        step();
        push("t1_after_release", P_RS, 16'h0000);
        drain();

        // Test 2: write is not bypassed; new value visible after the edge.
        reg_write = 1'b1; rd_addr = 3'd3; wr_data = 16'h1234; rs_addr = 3'd3;
        #1;
        push("t2_old_value", P_RS, 16'h0000);
        drain();
        model[3] = 16'h1234;
        step();
        reg_write = 1'b0;
        push("t2_new_value", P_RS, 16'h1234);
        drain();

        // Test 3: R0 write is discarded.
        rs_addr = 3'd0; rt_addr = 3'd0; dbg_addr = 3'd0;
        write(3'd0, 16'hFFFF);
        push("t3_r0_rs", P_RS, 16'h0000);
        push("t3_r0_rt", P_RT, 16'h0000);
        push("t3_r0_dbg", P_DBG, 16'h0000);
        drain();

        // Test 4: dual and debug reads.
        write(3'd2, 16'h00A5);
        write(3'd7, 16'h8000);
        rs_addr = 3'd2; rt_addr = 3'd7; dbg_addr = 3'd7;
        #1;
        push("t4_rs", P_RS, 16'h00A5);
        push("t4_rt", P_RT, 16'h8000);
        push("t4_dbg", P_DBG, 16'h8000);
        drain();
        dbg_addr = 3'd2;
        #1;
        push("t4_dbg_r2", P_DBG, 16'h00A5);
        drain();

        // Test 5: write disabled leaves R2 intact.
        reg_write = 1'b0; rd_addr = 3'd2; wr_data = 16'h5555;
        step();
        rs_addr = 3'd2;
        #1;
        push("t5_hold", P_RS, 16'h00A5);
        drain();

        // Fill all registers and read back on every port (all equal addresses).
        for (int i = 1; i < 8; i++) write(3'(i), 16'(16'h1357 * i ^ 16'hA0F0));
        for (int i = 0; i < 8; i++) begin
            rs_addr = 3'(i); rt_addr = 3'(i); dbg_addr = 3'(i);
            #1;
            push($sformatf("fill_rs%0d", i), P_RS, model[i]);
            push($sformatf("fill_rt%0d", i), P_RT, model[i]);
            push($sformatf("fill_dbg%0d", i), P_DBG, model[i]);
            drain();
        end

        // Test 6: flag capture and hold.
        flag_en = 1'b1; alu_zero = 1'b1; alu_cout = 1'b1; alu_ovf = 1'b0;
        step();
        push("t6_capture", P_FLAGS, 16'h0003);
        drain();
        flag_en = 1'b0; alu_zero = 1'b1; alu_cout = 1'b1; alu_ovf = 1'b1;
        step();
        push("t6_hold", P_FLAGS, 16'h0003);
        drain();

        // Flag capture and register write in the same cycle.
        flag_en = 1'b1; alu_zero = 1'b0; alu_cout = 1'b0; alu_ovf = 1'b1;
        rs_addr = 3'd4;
        write(3'd4, 16'hCAFE);
        flag_en = 1'b0;
        push("t6_ovf_only", P_FLAGS, 16'h0004);
        push("t6_concurrent_write", P_RS, 16'hCAFE);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_reg_file8x16
